// File: rtl/dpram_port_adapter.sv
// dpram_port_adapter: request-side front end for one port of the 64-bit
// dual-port data RAM. Converts byte-addressed, sized load/store requests into
// word address, byte enables and lane-replicated write data, then aligns and
// extends the 1-cycle-latency read data into a 2-entry response FIFO.
//
// Handshake: a transfer happens on a channel in any cycle where valid and
// ready are both high; valid never depends on ready. req_ready_o looks ahead
// at the response pop (rsp_ready_i -> req_ready_o is combinational), so full
// throughput is kept while the consumer drains.
module dpram_port_adapter #(
  parameter int DataWidth     = 64,
  parameter int Depth         = 1280,
  parameter int AddrWidth     = $clog2(Depth),
  parameter int ByteAddrWidth = AddrWidth + 3
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [ByteAddrWidth-1:0] req_addr_i,
  input  logic                     req_we_i,
  input  logic [1:0]               req_size_i,
  input  logic                     req_unsigned_i,
  input  logic [DataWidth-1:0]     req_wdata_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DataWidth-1:0]     rsp_rdata_o,
  output logic                     rsp_err_o,
  output logic [AddrWidth-1:0]     mem_addr_o,
  output logic [DataWidth-1:0]     mem_din_o,
  output logic [7:0]               mem_be_o,
  output logic                     mem_wren_o,
  output logic                     mem_rden_o,
  input  logic [DataWidth-1:0]     mem_dout_i
);

  localparam logic [AddrWidth:0] DepthW = Depth[AddrWidth:0];

  // Request decode
  logic [2:0]           req_off;
  logic [AddrWidth-1:0] req_waddr;
  logic                 align_err;
  logic                 range_err;
  logic                 req_err;
  logic                 req_acc;
  logic [7:0]           size_mask;

  // In-flight stage (the cycle the RAM is producing read data)
  logic       stage_valid_q, stage_valid_d;
  logic       stage_we_q, stage_we_d;
  logic [1:0] stage_size_q, stage_size_d;
  logic [2:0] stage_off_q, stage_off_d;
  logic       stage_uns_q, stage_uns_d;
  logic       stage_err_q, stage_err_d;

  // Response FIFO
  logic [DataWidth-1:0] fifo_rdata_q [2];
  logic [DataWidth-1:0] fifo_rdata_d [2];
  logic                 fifo_err_q [2];
  logic                 fifo_err_d [2];
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;

  logic [1:0]           occ;
  logic                 push;
  logic                 pop;
  logic [DataWidth-1:0] shifted;
  logic                 sign_bit;
  logic                 fill;
  logic [DataWidth-1:0] load_ext;
  logic [DataWidth-1:0] push_rdata;

  // Request decode, credit check and RAM strobes
  always_comb begin
    req_off   = req_addr_i[2:0];
    req_waddr = req_addr_i[ByteAddrWidth-1:3];
    case (req_size_i)
      2'd0:    align_err = 1'b0;
      2'd1:    align_err = req_off[0];
      2'd2:    align_err = |req_off[1:0];
      default: align_err = |req_off;
    endcase
    range_err = ({1'b0, req_waddr} >= DepthW);
    req_err   = align_err | range_err;

    case (req_size_i)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase

    rsp_valid_o = (count_q != 2'd0);
    pop         = rsp_valid_o & rsp_ready_i;
    push        = stage_valid_q;
    occ         = count_q + {1'b0, stage_valid_q};
    req_ready_o = rstn_i & ((occ < 2'd2) | pop);
    req_acc     = req_valid_i & req_ready_o;

    mem_addr_o = req_waddr;
    mem_wren_o = req_acc & req_we_i & ~req_err;
    mem_rden_o = req_acc & ~req_we_i & ~req_err;
    mem_be_o   = mem_wren_o ? (size_mask << req_off) : 8'h00;

    case (req_size_i)
      2'd0:    mem_din_o = {8{req_wdata_i[7:0]}};
      2'd1:    mem_din_o = {4{req_wdata_i[15:0]}};
      2'd2:    mem_din_o = {2{req_wdata_i[31:0]}};
      default: mem_din_o = req_wdata_i;
    endcase
  end

  // Load alignment and extension of the RAM word for the staged request
  always_comb begin
    shifted = mem_dout_i >> {stage_off_q, 3'b000};
    case (stage_size_q)
      2'd0:    sign_bit = shifted[7];
      2'd1:    sign_bit = shifted[15];
      default: sign_bit = shifted[31];
    endcase
    fill = ~stage_uns_q & sign_bit;
    case (stage_size_q)
      2'd0:    load_ext = {{56{fill}}, shifted[7:0]};
      2'd1:    load_ext = {{48{fill}}, shifted[15:0]};
      2'd2:    load_ext = {{32{fill}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
    push_rdata = (stage_err_q | stage_we_q) ? '0 : load_ext;

    rsp_rdata_o = rsp_valid_o ? fifo_rdata_q[rd_ptr_q] : '0;
    rsp_err_o   = rsp_valid_o & fifo_err_q[rd_ptr_q];
  end

  // Next-state for the stage register and the response FIFO
  always_comb begin
    stage_valid_d = req_acc;
    stage_we_d    = stage_we_q;
    stage_size_d  = stage_size_q;
    stage_off_d   = stage_off_q;
    stage_uns_d   = stage_uns_q;
    stage_err_d   = stage_err_q;
    if (req_acc) begin
      stage_we_d   = req_we_i;
      stage_size_d = req_size_i;
      stage_off_d  = req_off;
      stage_uns_d  = req_unsigned_i;
      stage_err_d  = req_err;
    end

    fifo_rdata_d = fifo_rdata_q;
    fifo_err_d   = fifo_err_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    // With the FIFO full, a same-cycle pop frees the head slot before the
    // push lands in it, so count stays at 2.
    if (push) begin
      fifo_rdata_d[wr_ptr_q] = push_rdata;
      fifo_err_d[wr_ptr_q]   = stage_err_q;
      wr_ptr_d               = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // State registers; reset discards any in-flight responses
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      stage_valid_q <= 1'b0;
      stage_we_q    <= 1'b0;
      stage_size_q  <= 2'd0;
      stage_off_q   <= 3'd0;
      stage_uns_q   <= 1'b0;
      stage_err_q   <= 1'b0;
      fifo_rdata_q  <= '{default: '0};
      fifo_err_q    <= '{default: 1'b0};
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      count_q       <= 2'd0;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_we_q    <= stage_we_d;
      stage_size_q  <= stage_size_d;
      stage_off_q   <= stage_off_d;
      stage_uns_q   <= stage_uns_d;
      stage_err_q   <= stage_err_d;
      fifo_rdata_q  <= fifo_rdata_d;
      fifo_err_q    <= fifo_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

endmodule

// File: doc/dpram_port_adapter.md
# dpram_port_adapter

Request-side front end for the 64-bit dual-port data RAM: turns byte-addressed, sized load/store requests (valid/ready) into one RAM port's word address, byte enables, lane-replicated write data and read/write strobes. It then aligns and sign/zero-extends the 1-cycle-latency read data. Responses are buffered in a 2-entry FIFO so a stalled consumer never loses RAM data. One instance drives port A or port B of the RAM; the core load/store unit sits upstream.

## Interface

- DataWidth, 64: data width in bits; only 64 is supported.
- Depth, 1280: RAM depth in 64-bit words.
- AddrWidth, $clog2(Depth): RAM word-address width.
- ByteAddrWidth, AddrWidth+3: request byte-address width.

- clk_i  in  1  single clock; also drives the attached RAM port clock.
- rstn_i  in  1  asynchronous, active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_addr_i  in  ByteAddrWidth  byte address.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  0 = byte, 1 = half, 2 = word, 3 = double.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0; ignored for double.
- req_wdata_i  in  64  store data, LSB-aligned.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumed when valid&ready.
- rsp_rdata_o  out  64  load result; 0 for stores and errors.
- rsp_err_o  out  1  misaligned or out-of-range request.
- mem_addr_o  out  AddrWidth  RAM word address, req_addr_i[ByteAddrWidth-1:3].
- mem_din_o  out  64  RAM write data.
- mem_be_o  out  8  RAM byte enables.
- mem_wren_o  out  1  RAM write enable.
- mem_rden_o  out  1  RAM read enable.
- mem_dout_i  in  64  RAM read data, valid the cycle after mem_rden_o.

## Operation

- **Offset and size.** off = req_addr_i[2:0]; nbytes = 1<<req_size_i.
- **Error condition.** err = (off mod nbytes != 0) OR (word address >= Depth).
- **Accept.** acc = req_valid_i & req_ready_o.
- **RAM strobes.** Combinational from the request:
  - mem_wren_o = acc & req_we_i & ~err
  - mem_rden_o = acc & ~req_we_i & ~err
  - mem_be_o = (2^nbytes - 1) << off when wren, else 0.
- **Write data.** mem_din_o replicates req_wdata_i[8*nbytes-1:0] across all 8/nbytes lanes. Example: byte 0xAB gives 0xABAB_ABAB_ABAB_ABAB.
- **Stage register.** Every accepted request, erroring ones included, loads the in-flight stage: valid, we, size, off, unsigned, err.
- **Response formatting.** The cycle after acceptance, the stage pushes one entry into the response FIFO:
  - err → rdata = 0, err = 1
  - store → rdata = 0, err = 0
  - load → rdata = mem_dout_i[8*off +: 8*nbytes], sign- or zero-extended to 64 bits.
- **Response FIFO.** 2 entries, in order. rsp_valid_o = FIFO not empty. Head is popped on rsp_valid_o & rsp_ready_i.
- **Credit counter.** occ = FIFO count + stage valid, range 0..2.
  - req_ready_o = rstn_i & (occ < 2 | (rsp_valid_o & rsp_ready_i)).
  - This is a combinational path rsp_ready_i → req_ready_o, and it is intended.
- **No overflow.** occ ≤ 2 guarantees a FIFO slot whenever the stage pushes.
- **Simultaneous push and pop** with FIFO count 2: the pop frees the slot first; count stays 2.
- **Reset.** Asynchronous reset clears the stage valid, the FIFO pointers and the count. In-flight responses are discarded. Because req_ready_o = 0 while rstn_i = 0, the RAM strobes are 0 during reset.

## Timing

- **Reset values.** req_ready_o = 0 while in reset, then 1 after release. rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0. mem_wren_o, mem_rden_o and mem_be_o are 0.
- **RAM strobes.** Asserted in the acceptance cycle T. The RAM samples them at the end of T.
- **Latency.** mem_dout_i is sampled in T+1 and the FIFO is written at the end of T+1. rsp_valid_o rises in T+2: 2 cycles accept-to-response.
- **Throughput.** 1 request per cycle while rsp_ready_i = 1.
- **Backpressure.** With rsp_ready_i held 0, at most 2 requests are accepted, then req_ready_o = 0.
- **Response stability.** rsp_* stay stable while rsp_valid_o = 1 and rsp_ready_i = 0.

## Test plan

- **Store then load, double.** Store double 0x1122334455667788 at byte addr 0x18, then load double at 0x18. Required: store cycle mem_addr_o = 3, be = 0xFF. Load response rdata = 0x1122334455667788, err = 0, arriving 2 cycles after accept.
- **Byte store and sign-extended load.** Store byte 0x80 at 0x1D, then load it signed and unsigned. Required: store be = 0x20 and din = 0x8080808080808080. Signed load returns 0xFFFFFFFFFFFFFF80; unsigned load returns 0x80.
- **Misaligned access.** Load word at 0x06. Required: mem_rden_o stays 0; response err = 1, rdata = 0.
- **Out-of-range access.** Store at word Depth (byte addr Depth*8). Required: mem_wren_o stays 0; response err = 1.
- **Backpressure.** Hold rsp_ready_i = 0 and issue 4 back-to-back loads. Required: exactly 2 accepted, then req_ready_o = 0. Releasing rsp_ready_i drains the responses in order, and the remaining requests then proceed at 1 per cycle.
- **Reset mid-operation.** Pulse rstn_i low with 2 responses pending. Required: rsp_valid_o drops immediately. After release, the first new load returns its own data with no stale response.
